mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 32 +++
 rtl/arb_pick.sv | 27 ++
 rtl/mem_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the two-master memory arbiter.
//   owner_e : requester identity (M0 = core, M1 = loader/DMA)
//   state_e : arbiter FSM states (IDLE, OWN0, OWN1)
//   F3_*    : funct3 access-size codes carried through to the memory port
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // The requester that did not win; used to advance the round-robin pointer.
    function automatic owner_e other_owner(input owner_e o);
        return (o == M0) ? M1 : M0;
    endfunction

endpackage

// File: rtl/arb_pick.sv
// -----------------------------------------------------------------------------
// arb_pick
// Two-way winner selection.
//   req[1:0] : request vector (bit i = requester i)
//   ptr      : requester that wins when both request
//   gnt[1:0] : one-hot grant (all zero when nobody requests)
// -----------------------------------------------------------------------------
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  owner_e     ptr,
    output logic [1:0] gnt
);

    always_comb begin
        // NOTE: assign a default first so every path drives gnt; a missing
        // branch in combinational logic would otherwise infer a latch.
        gnt = 2'b00;
        if (req[0] && (!req[1] || ptr == M0)) begin
            gnt = 2'b01;
        end else if (req[1]) begin
            gnt = 2'b10;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Arbitrates a single-ported memory between requester 0 (core) and
// requester 1 (loader/DMA). Grants are combinational in the request cycle;
// read data returns one cycle later and is steered back by a registered tag.
// A requester may hold the port with m<i>_lock for up to MAX_LOCK grants.
//
// Build option: define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration;
// otherwise requester 0 has fixed priority.
//
// Ports:
//   clk, reset_n                        clock, async active-low reset
//   m<i>_req/_we/_lock/_addr/_wdata/_funct3   requester i access
//   m<i>_gnt                            access accepted this cycle
//   m<i>_rvalid, m<i>_rdata             read return (rdata is 0 when !rvalid)
//   mem_we/_addr/_wdata/_funct3         memory command (all 0 when idle)
//   mem_rdata                           memory read data, one cycle latency
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_LOCK = 8
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic              m0_lock,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [2:0]        m0_funct3,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic              m1_lock,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [2:0]        m1_funct3,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,

    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        mem_funct3,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Wide enough to hold MAX_LOCK itself for the release comparison.
    localparam int CNT_W = $clog2(MAX_LOCK + 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  cnt_next;
    logic              rd_pend_q, rd_pend_d;
    owner_e            rd_owner_q, rd_owner_d;

    logic [1:0]        req;
    logic [1:0]        pick_gnt;
    logic [1:0]        gnt_raw;
    logic [1:0]        gnt;
    owner_e            pick_ptr;
    owner_e            gnt_owner;
    logic              gnt_lock;
    logic              gnt_we;

    assign req = {m1_req, m0_req};

`ifdef MEM_ARB_ROUND_ROBIN_EN
    owner_e ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (|gnt) begin
            ptr_d = other_owner(gnt_owner);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= M0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign pick_ptr = ptr_q;
`else
    assign pick_ptr = M0;
`endif

    arb_pick u_pick (
        .req (req),
        .ptr (pick_ptr),
        .gnt (pick_gnt)
    );

    // Grant: open arbitration in IDLE, owner-only while locked. Grants are
    // masked during reset so every output is 0 while reset_n is low.
    always_comb begin
        unique case (state_q)
            IDLE:    gnt_raw = pick_gnt;
            OWN0:    gnt_raw = {1'b0, m0_req};
            OWN1:    gnt_raw = {m1_req, 1'b0};
            default: gnt_raw = 2'b00;
        endcase
        gnt = reset_n ? gnt_raw : 2'b00;
    end

    assign m0_gnt    = gnt[0];
    assign m1_gnt    = gnt[1];
    assign gnt_owner = gnt[1] ? M1 : M0;
    assign gnt_lock  = gnt[1] ? m1_lock : m0_lock;
    assign gnt_we    = gnt[1] ? m1_we   : m0_we;

    // Memory command mux; idle port drives zeros.
    always_comb begin
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_funct3 = 3'b000;
        if (gnt[0]) begin
            mem_we     = m0_we;
            mem_addr   = m0_addr;
            mem_wdata  = m0_wdata;
            mem_funct3 = m0_funct3;
        end else if (gnt[1]) begin
            mem_we     = m1_we;
            mem_addr   = m1_addr;
            mem_wdata  = m1_wdata;
            mem_funct3 = m1_funct3;
        end
    end

    // Lock FSM. cnt_next counts this grant in the current lock run; a grant
    // from IDLE starts a new run at 1.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cnt_next = ((state_q == IDLE) ? '0 : cnt_q) + CNT_W'(1);
        if (|gnt) begin
            if (gnt_lock && (cnt_next < CNT_W'(MAX_LOCK))) begin
                state_d = (gnt_owner == M1) ? OWN1 : OWN0;
                cnt_d   = cnt_next;
            end else begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        end else if (state_q != IDLE) begin
            // Owner dropped its request: release the lock.
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    // Read-return tag: captured at grant time so the data goes back to the
    // requester that issued the read even if ownership changes next cycle.
    assign rd_pend_d  = (|gnt) && !gnt_we;
    assign rd_owner_d = gnt_owner;

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples
        // pre-edge values regardless of statement order.
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= M0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    assign m0_rvalid = rd_pend_q && (rd_owner_q == M0);
    assign m1_rvalid = rd_pend_q && (rd_owner_q == M1);
    assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
    assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed self-checking bench for mem_arbiter (MAX_LOCK = 8). Inputs change
// 1 ns after a rising edge; outputs are sampled 3-4 ns later, mid-cycle.
// Contention expectations follow MEM_ARB_ROUND_ROBIN_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int MAX_LOCK = 8;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic              clk;
    logic              reset_n;
    logic              m0_req, m0_we, m0_lock;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic [2:0]        m0_funct3;
    logic              m0_gnt, m0_rvalid;
    logic [DATA_W-1:0] m0_rdata;
    logic              m1_req, m1_we, m1_lock;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic [2:0]        m1_funct3;
    logic              m1_gnt, m1_rvalid;
    logic [DATA_W-1:0] m1_rdata;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [2:0]        mem_funct3;
    logic [DATA_W-1:0] mem_rdata;

    int vec_cnt = 0;
    int err_cnt = 0;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_LOCK(MAX_LOCK)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_funct3(m0_funct3), .m0_gnt(m0_gnt),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_funct3(m1_funct3), .m1_gnt(m1_gnt),
        .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_funct3(mem_funct3), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_req = 1'b0; m0_we = 1'b0; m0_lock = 1'b0; m0_addr = '0; m0_wdata = '0; m0_funct3 = F3_W;
        m1_req = 1'b0; m1_we = 1'b0; m1_lock = 1'b0; m1_addr = '0; m1_wdata = '0; m1_funct3 = F3_W;
    endtask

    task automatic test_reset();
        m0_req = 1'b1; m0_addr = 32'h100;
        #2;
        vec_cnt++; if (m0_gnt !== 1'b0) begin err_cnt++; $display("FAIL rst_m0_gnt: got %0b exp 0", m0_gnt); end
        vec_cnt++; if (m1_gnt !== 1'b0) begin err_cnt++; $display("FAIL rst_m1_gnt: got %0b exp 0", m1_gnt); end
        vec_cnt++; if (mem_addr !== 32'h0) begin err_cnt++; $display("FAIL rst_mem_addr: got %h exp 0", mem_addr); end
        vec_cnt++; if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin err_cnt++; $display("FAIL rst_rvalid: got %0b%0b exp 00", m1_rvalid, m0_rvalid); end
        m0_req = 1'b0;
        step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_contention();
        bit exp0, prev0;
        prev0 = 1'b0;
        m0_req = 1'b1; m0_addr = 32'h10;
        m1_req = 1'b1; m1_addr = 32'h20;
        for (int k = 0; k < 4; k++) begin
            exp0 = RR ? (k % 2 == 0) : 1'b1;
            #3;
            vec_cnt++; if (m0_gnt !== exp0 || m1_gnt !== !exp0) begin err_cnt++; $display("FAIL cont_gnt[%0d]: got %0b%0b exp %0b%0b", k, m1_gnt, m0_gnt, !exp0, exp0); end
            vec_cnt++; if (mem_addr !== (exp0 ? 32'h10 : 32'h20)) begin err_cnt++; $display("FAIL cont_addr[%0d]: got %h", k, mem_addr); end
            if (k > 0) begin
                vec_cnt++; if (m0_rvalid !== prev0 || m1_rvalid !== !prev0) begin err_cnt++; $display("FAIL cont_rvalid[%0d]: got %0b%0b exp %0b%0b", k, m1_rvalid, m0_rvalid, !prev0, prev0); end
            end
            prev0 = exp0;
            step();
        end
        idle_inputs();
        #3;
        vec_cnt++; if (m0_rvalid !== prev0 || m1_rvalid !== !prev0) begin err_cnt++; $display("FAIL cont_rvalid_last: got %0b%0b", m1_rvalid, m0_rvalid); end
        step();
    endtask

    task automatic test_single_read();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h100; m0_funct3 = F3_W;
        #3;
        vec_cnt++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin err_cnt++; $display("FAIL rd_gnt: got %0b%0b exp 01", m1_gnt, m0_gnt); end
        vec_cnt++; if (mem_addr !== 32'h100 || mem_we !== 1'b0 || mem_funct3 !== F3_W) begin err_cnt++; $display("FAIL rd_mem_cmd: got we=%0b addr=%h f3=%0d", mem_we, mem_addr, mem_funct3); end
        step();
        idle_inputs();
        m0_wdata = 32'h77777777;
        mem_rdata = 32'hDEADBEEF;
        #3;
        vec_cnt++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hDEADBEEF) begin err_cnt++; $display("FAIL rd_return: got v=%0b d=%h exp v=1 d=deadbeef", m0_rvalid, m0_rdata); end
        vec_cnt++; if (m1_rvalid !== 1'b0 || m1_rdata !== 32'h0) begin err_cnt++; $display("FAIL rd_m1_quiet: got v=%0b d=%h", m1_rvalid, m1_rdata); end
        vec_cnt++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_we !== 1'b0) begin err_cnt++; $display("FAIL idle_mem: got we=%0b addr=%h wd=%h", mem_we, mem_addr, mem_wdata); end
        step();
        mem_rdata = 32'h12345678;
        #3;
        vec_cnt++; if (m0_rvalid !== 1'b0 || m0_rdata !== 32'h0) begin err_cnt++; $display("FAIL rd_rdata_zero: got v=%0b d=%h", m0_rvalid, m0_rdata); end
        step();
    endtask

    task automatic test_lock_max();
        for (int k = 0; k < MAX_LOCK; k++) begin
            m1_req = 1'b1; m1_we = 1'b1; m1_lock = 1'b1;
            m1_addr = 32'h200 + 32'(4 * k); m1_wdata = 32'hB000 + 32'(k);
            m0_req = (k > 0); m0_we = 1'b0; m0_lock = 1'b0; m0_addr = 32'h300;
            #3;
            vec_cnt++; if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0) begin err_cnt++; $display("FAIL lock_gnt[%0d]: got %0b%0b exp 10", k, m1_gnt, m0_gnt); end
            vec_cnt++; if (mem_we !== 1'b1 || mem_addr !== 32'h200 + 32'(4 * k) || mem_wdata !== 32'hB000 + 32'(k)) begin err_cnt++; $display("FAIL lock_cmd[%0d]: got we=%0b addr=%h wd=%h", k, mem_we, mem_addr, mem_wdata); end
            vec_cnt++; if (m1_rvalid !== 1'b0) begin err_cnt++; $display("FAIL lock_no_rvalid[%0d]: got %0b exp 0", k, m1_rvalid); end
            step();
        end
        #3;
        vec_cnt++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin err_cnt++; $display("FAIL lock_expire_gnt: got %0b%0b exp 01", m1_gnt, m0_gnt); end
        vec_cnt++; if (mem_addr !== 32'h300 || mem_we !== 1'b0) begin err_cnt++; $display("FAIL lock_expire_cmd: got we=%0b addr=%h", mem_we, mem_addr); end
        step();
        idle_inputs();
        mem_rdata = 32'h0BADF00D;
        #3;
        vec_cnt++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h0BADF00D || m1_rvalid !== 1'b0) begin err_cnt++; $display("FAIL lock_expire_rd: got v0=%0b d0=%h v1=%0b", m0_rvalid, m0_rdata, m1_rvalid); end
        step();
    endtask

    task automatic test_lock_release();
        // Lock, then release with lock=0 while m1 waits.
        m0_req = 1'b1; m0_we = 1'b1; m0_lock = 1'b1; m0_addr = 32'h500;
        #3;
        vec_cnt++; if (m0_gnt !== 1'b1) begin err_cnt++; $display("FAIL rel_a_gnt: got %0b exp 1", m0_gnt); end
        step();
        m0_lock = 1'b0; m0_addr = 32'h504;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h600;
        #3;
        vec_cnt++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin err_cnt++; $display("FAIL rel_hold_gnt: got %0b%0b exp 01", m1_gnt, m0_gnt); end
        step();
        m0_addr = 32'h508;
        #3;
        vec_cnt++; if (m0_gnt !== !RR || m1_gnt !== RR) begin err_cnt++; $display("FAIL rel_nobubble_gnt: got %0b%0b exp %0b%0b", m1_gnt, m0_gnt, RR, !RR); end
        step();
        idle_inputs();
        step();
        // Lock, then owner drops req: one cycle with no grant, then m1 wins.
        m0_req = 1'b1; m0_we = 1'b1; m0_lock = 1'b1; m0_addr = 32'h50C;
        #3;
        vec_cnt++; if (m0_gnt !== 1'b1) begin err_cnt++; $display("FAIL drop_lock_gnt: got %0b exp 1", m0_gnt); end
        step();
        idle_inputs();
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h604;
        #3;
        vec_cnt++; if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0 || mem_addr !== 32'h0) begin err_cnt++; $display("FAIL drop_own_only: got %0b%0b addr=%h exp 00 0", m1_gnt, m0_gnt, mem_addr); end
        step();
        #3;
        vec_cnt++; if (m1_gnt !== 1'b1 || mem_addr !== 32'h604) begin err_cnt++; $display("FAIL drop_after_gnt: got %0b addr=%h", m1_gnt, mem_addr); end
        step();
        idle_inputs();
        step();
    endtask

    task automatic test_read_then_write();
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h40;
        #3;
        vec_cnt++; if (m1_gnt !== 1'b1 || mem_addr !== 32'h40 || mem_we !== 1'b0) begin err_cnt++; $display("FAIL rw_m1_rd: got gnt=%0b addr=%h we=%0b", m1_gnt, mem_addr, mem_we); end
        step();
        idle_inputs();
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h44; m0_wdata = 32'hCAFEF00D; m0_funct3 = F3_H;
        mem_rdata = 32'hA5A5A5A5;
        #3;
        vec_cnt++; if (m0_gnt !== 1'b1 || m1_rvalid !== 1'b1 || m1_rdata !== 32'hA5A5A5A5) begin err_cnt++; $display("FAIL rw_overlap: got gnt0=%0b v1=%0b d1=%h", m0_gnt, m1_rvalid, m1_rdata); end
        vec_cnt++; if (mem_we !== 1'b1 || mem_addr !== 32'h44 || mem_wdata !== 32'hCAFEF00D || mem_funct3 !== F3_H) begin err_cnt++; $display("FAIL rw_wr_cmd: got we=%0b addr=%h wd=%h f3=%0d", mem_we, mem_addr, mem_wdata, mem_funct3); end
        vec_cnt++; if (m0_rvalid !== 1'b0) begin err_cnt++; $display("FAIL rw_m0_rvalid: got %0b exp 0", m0_rvalid); end
        step();
        idle_inputs();
        #3;
        vec_cnt++; if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0 || m1_rdata !== 32'h0) begin err_cnt++; $display("FAIL rw_wr_no_rvalid: got v0=%0b v1=%0b d1=%h", m0_rvalid, m1_rvalid, m1_rdata); end
        step();
    endtask

    task automatic test_reset_mid_lock();
        m1_req = 1'b1; m1_we = 1'b0; m1_lock = 1'b1; m1_addr = 32'h80;
        #3;
        vec_cnt++; if (m1_gnt !== 1'b1) begin err_cnt++; $display("FAIL rml_first_gnt: got %0b exp 1", m1_gnt); end
        step();
        m1_addr = 32'h84;
        mem_rdata = 32'h11112222;
        #3;
        vec_cnt++; if (m1_gnt !== 1'b1 || m1_rvalid !== 1'b1) begin err_cnt++; $display("FAIL rml_own1: got gnt=%0b v=%0b exp 1 1", m1_gnt, m1_rvalid); end
        step();
        m1_addr = 32'h88;
        m0_req = 1'b1; m0_addr = 32'h90;
        #1;
        vec_cnt++; if (m0_gnt !== 1'b0 || m1_gnt !== 1'b1 || m1_rvalid !== 1'b1) begin err_cnt++; $display("FAIL rml_pre_reset: got g0=%0b g1=%0b v1=%0b", m0_gnt, m1_gnt, m1_rvalid); end
        reset_n = 1'b0;
        #1;
        vec_cnt++; if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin err_cnt++; $display("FAIL rml_gnt_zero: got %0b%0b exp 00", m1_gnt, m0_gnt); end
        vec_cnt++; if (m1_rvalid !== 1'b0 || m1_rdata !== 32'h0 || m0_rvalid !== 1'b0 || m0_rdata !== 32'h0) begin err_cnt++; $display("FAIL rml_rd_zero: got v1=%0b d1=%h v0=%0b", m1_rvalid, m1_rdata, m0_rvalid); end
        vec_cnt++; if (mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_funct3 !== 3'b000) begin err_cnt++; $display("FAIL rml_mem_zero: got we=%0b addr=%h", mem_we, mem_addr); end
        idle_inputs();
        step();
        step();
        reset_n = 1'b1;
        #3;
        vec_cnt++; if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin err_cnt++; $display("FAIL rml_stray_rvalid: got %0b%0b exp 00", m1_rvalid, m0_rvalid); end
        step();
        m0_req = 1'b1; m0_addr = 32'hA0;
        m1_req = 1'b1; m1_addr = 32'hB0;
        #3;
        vec_cnt++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin err_cnt++; $display("FAIL rml_idle_after: got %0b%0b exp 01", m1_gnt, m0_gnt); end
        step();
        idle_inputs();
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        reset_n   = 1'b0;
        mem_rdata = '0;
        idle_inputs();
        test_reset();
        test_contention();
        test_single_read();
        test_lock_max();
        test_lock_release();
        test_read_then_write();
        test_reset_mid_lock();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
